// File: rtl/rmii_frame_tx_pkg.sv
// Shared definitions for the RMII frame transmitter: FSM states, framing constants
// and the single-bit reflected CRC-32 step.
package rmii_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam int          PREAMBLE_DIBITS = 32;
  localparam logic [7:0]  SFD             = 8'hD5;
  localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE     = 32'hC704_DD7B;
  localparam int          SLOW_DIV        = 10;

  // One bit of the LSB-first CRC-32 shift (reflected form of 0x04C11DB7).
  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY_REFL : 32'h0);
  endfunction

endpackage

// File: rtl/rmii_frame_tx_crc32_d2.sv
// CRC-32 accumulator consuming one RMII dibit (two bits, bit 0 first) per enabled clock.
module rmii_frame_tx_crc32_d2
  import rmii_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_bit(crc_bit(crc, d[0]), d[1]);
    end
  end

endmodule

// File: rtl/rmii_frame_tx.sv
// RMII frame transmitter: preamble/SFD, body read from a byte RAM, zero padding,
// CRC-32 FCS and inter-frame gap, serialised as LSB-first dibits at 10 or 100 Mbit/s.
module rmii_frame_tx
  import rmii_frame_tx_pkg::*;
#(
  parameter int L       = 8,
  parameter int MIN_LEN = 60,
  parameter int IFG     = 96,
  parameter int PAD_EN  = 1,
  parameter int FCS_EN  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         fast_eth,
  input  logic [L-1:0] count,
  input  logic         abort,
  output logic [L-1:0] addr,
  input  logic [7:0]   rdata,
  output logic         rm_tx_en,
  output logic [1:0]   rm_tx_data,
  output logic         rdy,
  output logic         done
);

  localparam int          LP1     = L + 1;
  localparam int          GAP     = IFG / 2;
  localparam int          GW      = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP);
  localparam logic [L:0]  MIN_W   = LP1'(MIN_LEN);
  localparam logic [4:0]  PRE_END = 5'(PREAMBLE_DIBITS - 1);

  state_t        state;
  state_t        after_pad;
  logic          spd;
  logic [3:0]    presc;
  logic          tick_slow;
  logic          tick;
  logic [L-1:0]  cnt_q;
  logic [L:0]    cnt_w;
  logic [L:0]    byte_cnt;
  logic [L:0]    byte_nx;
  logic [4:0]    dcnt;
  logic [1:0]    fcs_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    sh;
  logic [7:0]    cur_byte;
  logic [1:0]    nd;
  logic [31:0]   crc;
  logic [31:0]   inv_crc;
  logic          byte_st;
  logic          pad_needed;
  logic          crc_init;
  logic          crc_en;

  assign tick_slow  = (presc == 4'(SLOW_DIV - 1));
  assign tick       = spd || tick_slow;
  assign cnt_w      = {1'b0, cnt_q};
  assign byte_nx    = byte_cnt + LP1'(1);
  assign byte_st    = (state == ST_DATA) || (state == ST_PAD) || (state == ST_FCS);
  assign pad_needed = (PAD_EN != 0) && (cnt_w < MIN_W);
  assign crc_init   = (state == ST_IDLE) && start && (count != '0);
  assign crc_en     = tick && !abort && ((state == ST_DATA) || (state == ST_PAD));

  // Byte being serialised: RAM data, zero pad or the inverted CRC, LSB byte first.
  always_comb begin
    inv_crc   = ~crc;
    after_pad = (FCS_EN != 0) ? ST_FCS : ST_IFG;
    case (state)
      ST_DATA: cur_byte = rdata;
      ST_FCS:  cur_byte = inv_crc[{fcs_cnt, 3'b000} +: 8];
      default: cur_byte = 8'h00;
    endcase
    nd = (dcnt[1:0] == 2'd0) ? cur_byte[1:0] : sh[1:0];
  end

  rmii_frame_tx_crc32_d2 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (nd),
    .crc  (crc)
  );

  always_ff @(posedge clk) begin
    if (tick && byte_st) begin
      sh <= (dcnt[1:0] == 2'd0) ? {2'b00, cur_byte[7:2]} : {2'b00, sh[7:2]};
    end
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state      <= ST_IDLE;
      spd        <= 1'b1;
      presc      <= '0;
      cnt_q      <= '0;
      byte_cnt   <= '0;
      dcnt       <= '0;
      fcs_cnt    <= '0;
      gap_cnt    <= '0;
      addr       <= '0;
      rm_tx_en   <= 1'b0;
      rm_tx_data <= 2'b00;
      rdy        <= 1'b1;
    end else begin
      presc <= tick_slow ? 4'd0 : presc + 4'd1;
      if (state == ST_IDLE) begin
        if (start && count != '0) begin
          state      <= ST_PRE;
          cnt_q      <= count;
          spd        <= fast_eth;
          presc      <= '0;
          rdy        <= 1'b0;
          addr       <= '0;
          byte_cnt   <= '0;
          fcs_cnt    <= '0;
          dcnt       <= 5'd1;
          rm_tx_en   <= 1'b1;
          rm_tx_data <= SFD[1:0];
        end
      end else if (abort && state != ST_IFG) begin
        // Abort edge counts as the first gap dibit; prescaler restarts so the gap stays full length.
        state      <= ST_IFG;
        gap_cnt    <= GW'(1);
        presc      <= '0;
        rm_tx_en   <= 1'b0;
        rm_tx_data <= 2'b00;
      end else if (tick) begin
        case (state)
          ST_PRE: begin
            rm_tx_data <= (dcnt == PRE_END) ? SFD[7:6] : SFD[1:0];
            if (dcnt == PRE_END) begin
              dcnt  <= '0;
              state <= ST_DATA;
            end else begin
              dcnt <= dcnt + 5'd1;
            end
          end
          ST_DATA, ST_PAD, ST_FCS: begin
            rm_tx_data <= nd;
            dcnt       <= dcnt + 5'd1;
            // Address moves two dibits early so RAM data is ready for the next byte at 100 Mb.
            if (state == ST_DATA && dcnt[1:0] == 2'd2 && byte_nx < cnt_w) begin
              addr <= addr + L'(1);
            end
            if (dcnt[1:0] == 2'd3) begin
              dcnt    <= '0;
              gap_cnt <= '0;
              if (state == ST_FCS) begin
                fcs_cnt <= fcs_cnt + 2'd1;
                if (fcs_cnt == 2'd3) state <= ST_IFG;
              end else begin
                byte_cnt <= byte_nx;
                if (state == ST_DATA && byte_nx == cnt_w) begin
                  state <= pad_needed ? ST_PAD : after_pad;
                end else if (state == ST_PAD && byte_nx == MIN_W) begin
                  state <= after_pad;
                end
              end
            end
          end
          ST_IFG: begin
            if (gap_cnt == GAP_END) begin
              done  <= 1'b1;
              rdy   <= 1'b1;
              state <= ST_IDLE;
            end else begin
              gap_cnt    <= gap_cnt + GW'(1);
              rm_tx_en   <= 1'b0;
              rm_tx_data <= 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rmii_frame_tx.sv
// Directed bench for rmii_frame_tx: one instance with padding, one without, sharing a byte RAM image.
module tb_rmii_frame_tx;
  import rmii_frame_tx_pkg::*;

  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, fast_eth, abort, abort_b, sel;
  logic [7:0] count;
  logic [7:0] addr_a, addr_b, rdata_a, rdata_b;
  logic       en_a, en_b, rdy_a, rdy_b, done_a, done_b;
  logic [1:0] txd_a, txd_b;
  logic       o_en, o_rdy, o_done;
  logic [1:0] o_txd;
  logic [7:0] o_addr;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] rx [$];
  logic [7:0] rxb [$];
  int en_clks, gap_clks, max_addr;
  bit unstable, timeout;

  rmii_frame_tx #(.L(8), .MIN_LEN(60), .IFG(96), .PAD_EN(1), .FCS_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .fast_eth(fast_eth), .count(count), .abort(abort),
    .addr(addr_a), .rdata(rdata_a), .rm_tx_en(en_a), .rm_tx_data(txd_a), .rdy(rdy_a), .done(done_a)
  );

  rmii_frame_tx #(.L(8), .MIN_LEN(60), .IFG(96), .PAD_EN(0), .FCS_EN(1)) u_nopad (
    .clk(clk), .rst(rst), .start(start_b), .fast_eth(fast_eth), .count(count), .abort(abort_b),
    .addr(addr_b), .rdata(rdata_b), .rm_tx_en(en_b), .rm_tx_data(txd_b), .rdy(rdy_b), .done(done_b)
  );

  always @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

  always_comb begin
    o_en   = sel ? en_b   : en_a;
    o_txd  = sel ? txd_b  : txd_a;
    o_rdy  = sel ? rdy_b  : rdy_a;
    o_done = sel ? done_b : done_a;
    o_addr = sel ? addr_b : addr_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_start(input bit s, input bit fe, input logic [7:0] c);
    @(negedge clk);
    sel = s; fast_eth = fe; count = c;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Called at the first negedge after the start edge; records one dibit per div clocks.
  task automatic capture(input int div, input int busy_at);
    int n;
    logic [1:0] prev;
    n = 0; prev = 2'b00;
    rx.delete(); en_clks = 0; gap_clks = 0; unstable = 0; timeout = 0; max_addr = 0;
    while (o_en === 1'b1 && n < LIMIT) begin
      if (en_clks % div == 0) begin
        rx.push_back(o_txd);
        prev = o_txd;
      end else if (o_txd !== prev) begin
        unstable = 1;
      end
      if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
      start_a = 1'b0; start_b = 1'b0;
      if (en_clks == busy_at) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        count = 8'd3;
        fast_eth = ~fast_eth;
      end
      en_clks++; n++;
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
    while (o_done !== 1'b1 && n < LIMIT) begin
      gap_clks++; n++;
      @(negedge clk);
    end
    timeout = (n >= LIMIT);
    rxb.delete();
    for (int i = 0; i + 3 < rx.size(); i += 4) rxb.push_back({rx[i+3], rx[i+2], rx[i+1], rx[i]});
  endtask

  // Straight MSB-first LFSR over bytes in wire order (bit 0 first).
  function automatic logic [31:0] residue(input int first, input int nbytes);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = first; i < first + nbytes; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ rxb[i][b];
        c = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic check_frame(input string tag, input int body_len, input int mem_len, input int div);
    int total;
    logic [63:0] pre;
    logic [7:0] exp_b;
    total = 8 + body_len + 4;
    chk({tag, "/timeout"}, timeout, 0);
    chk({tag, "/tx_en_clks"}, en_clks, total * 4 * div);
    chk({tag, "/gap_clks"}, gap_clks, 48 * div);
    chk({tag, "/unstable"}, unstable, 0);
    chk({tag, "/rdy_at_done"}, o_rdy, 1);
    chk({tag, "/bytes"}, rxb.size(), total);
    if (rxb.size() >= total) begin
      pre = '0;
      for (int i = 0; i < 8; i++) pre[8*i +: 8] = rxb[i];
      chk({tag, "/preamble"}, pre, 64'hD555_5555_5555_5555);
      for (int i = 0; i < body_len; i++) begin
        exp_b = (i < mem_len) ? mem[i] : 8'h00;
        chk($sformatf("%s/body[%0d]", tag, i), rxb[8+i], exp_b);
      end
      chk({tag, "/residue"}, residue(8, body_len + 4), CRC_RESIDUE);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    int gap;
    bit flag;
    msg = "123456789";
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; fast_eth = 1'b1; count = '0;
    abort = 1'b0; abort_b = 1'b0; sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = (i < 9) ? msg[i] : 8'(i * 37 + 11);
    repeat (3) @(negedge clk);

    chk("reset/rdy", rdy_a, 1);
    chk("reset/tx_en", en_a, 0);
    chk("reset/tx_data", txd_a, 0);
    chk("reset/done", done_a, 0);
    chk("reset/addr", addr_a, 0);
    chk("reset/rdy_nopad", rdy_b, 1);
    rst = 1'b0;
    @(negedge clk);

    // 100 Mb, no padding, "123456789"
    send_start(1'b1, 1'b1, 8'd9);
    chk("t1/rdy_low", o_rdy, 0);
    chk("t1/first_dibit", o_txd, 2'b01);
    capture(1, -1);
    check_frame("t1", 9, 9, 1);
    chk("t1/fcs", {rxb[20], rxb[19], rxb[18], rxb[17]}, 32'hCBF4_3926);
    @(negedge clk);
    chk("t1/done_pulse", o_done, 0);

    // 100 Mb, padded short body, with a start/count/speed change injected mid-frame
    send_start(1'b0, 1'b1, 8'd14);
    capture(1, 10);
    check_frame("t2", 60, 14, 1);

    // 10 Mb, 60-byte body
    send_start(1'b0, 1'b0, 8'd60);
    capture(10, -1);
    check_frame("t3", 60, 60, 10);

    // abort during the 20th body byte
    send_start(1'b0, 1'b1, 8'd60);
    repeat (108) @(negedge clk);
    chk("t4/tx_en_before", o_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4/tx_en_after", o_en, 0);
    chk("t4/tx_data_after", o_txd, 0);
    gap = 0;
    while (o_done !== 1'b1 && gap < LIMIT) begin
      gap++;
      @(negedge clk);
    end
    chk("t4/gap_clks", gap, 48);
    chk("t4/rdy_at_done", o_rdy, 1);
    start_a = 1'b1; count = 8'd1; fast_eth = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("t5/rdy_low", o_rdy, 0);
    capture(1, -1);
    check_frame("t5", 60, 1, 1);

    // start with count=0 is ignored
    @(negedge clk);
    start_a = 1'b1; count = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_en !== 1'b0 || o_done !== 1'b0 || o_rdy !== 1'b1) flag = 1;
      @(negedge clk);
    end
    chk("t6/no_activity", flag, 0);

    // reset in the middle of the preamble
    send_start(1'b0, 1'b1, 8'd20);
    repeat (5) @(negedge clk);
    chk("t7/tx_en_before", o_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7/tx_en", o_en, 0);
    chk("t7/tx_data", o_txd, 0);
    chk("t7/rdy", o_rdy, 1);
    chk("t7/addr", o_addr, 0);
    flag = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_done !== 1'b0 || o_en !== 1'b0) flag = 1;
      @(negedge clk);
    end
    chk("t7/no_done", flag, 0);

    // largest body: address walks 0..254
    send_start(1'b0, 1'b1, 8'd255);
    capture(1, -1);
    check_frame("t8", 255, 255, 1);
    chk("t8/max_addr", max_addr, 254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
